// File: rtl/image_loader.sv
// Streams one square frame of pixels into a byte-wide memory.
// Once the frame is stored it holds ready until the processing controller reports completion.
module image_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_req,
  input  logic [8:0]  dim,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        proc_done,
  output logic        writeEnable,
  output logic [15:0] address,
  output logic [7:0]  data_to_write,
  output logic        ready,
  output logic        err,
  output logic [7:0]  frames_loaded
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_PROC} state_t;

  state_t      state_reg, state_next;
  logic [8:0]  dim_reg, dim_next;
  logic [16:0] count_reg, count_next;
  logic        we_reg, we_next;
  logic [15:0] addr_reg, addr_next;
  logic [7:0]  data_reg, data_next;
  logic        ready_reg, ready_next;
  logic        err_reg, err_next;
  logic [7:0]  frames_reg, frames_next;

  logic        dim_ok;
  logic        beat;
  logic [16:0] dim_wide;
  logic [16:0] total;

  assign dim_ok = (dim != 9'd0) && (dim <= 9'd256);

  // The largest frame is 256*256 = 65536 pixels, which needs 17 bits.
  assign dim_wide = {8'd0, dim_reg};
  assign total    = dim_wide * dim_wide;

  assign in_ready = (state_reg == LOAD);
  assign beat     = in_valid && in_ready;

  always_comb begin
    state_next  = state_reg;
    dim_next    = dim_reg;
    count_next  = count_reg;
    we_next     = 1'b0;
    addr_next   = addr_reg;
    data_next   = data_reg;
    ready_next  = 1'b0;
    err_next    = 1'b0;
    frames_next = frames_reg;
    case (state_reg)
      IDLE: begin
        if (load_req) begin
          if (dim_ok) begin
            dim_next   = dim;
            count_next = 17'd0;
            state_next = LOAD;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      LOAD: begin
        if (beat) begin
          we_next    = 1'b1;
          addr_next  = count_reg[15:0];
          data_next  = in_data;
          count_next = count_reg + 17'd1;
          if (count_reg == total - 17'd1) begin
            state_next = WAIT_PROC;
          end
        end
      end
      WAIT_PROC: begin
        // ready is registered, so it trails the final write strobe by one cycle.
        if (proc_done) begin
          state_next  = IDLE;
          frames_next = frames_reg + 8'd1;
        end else begin
          ready_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= IDLE;
      dim_reg    <= 9'd0;
      count_reg  <= 17'd0;
      we_reg     <= 1'b0;
      addr_reg   <= 16'd0;
      data_reg   <= 8'd0;
      ready_reg  <= 1'b0;
      err_reg    <= 1'b0;
      frames_reg <= 8'd0;
    end else begin
      state_reg  <= state_next;
      dim_reg    <= dim_next;
      count_reg  <= count_next;
      we_reg     <= we_next;
      addr_reg   <= addr_next;
      data_reg   <= data_next;
      ready_reg  <= ready_next;
      err_reg    <= err_next;
      frames_reg <= frames_next;
    end
  end

  assign writeEnable   = we_reg;
  assign address       = addr_reg;
  assign data_to_write = data_reg;
  assign ready         = ready_reg;
  assign err           = err_reg;
  assign frames_loaded = frames_reg;

endmodule

// File: tb/tb_image_loader.sv
// Self-checking bench for image_loader: random pixel streams checked against a
// transaction-level model (beat index -> address, one-cycle write latency, ready timing).
module tb_image_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_req;
  logic [8:0]  dim;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        proc_done;
  logic        writeEnable;
  logic [15:0] address;
  logic [7:0]  data_to_write;
  logic        ready;
  logic        err;
  logic [7:0]  frames_loaded;

  int checks = 0;
  int errors = 0;
  int exp_frames = 0;
  int last_addr = 0;
  int last_data = 0;

  always #5 clk = ~clk;

  image_loader dut (
    .clk(clk), .rst(rst), .load_req(load_req), .dim(dim),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .proc_done(proc_done), .writeEnable(writeEnable), .address(address),
    .data_to_write(data_to_write), .ready(ready), .err(err),
    .frames_loaded(frames_loaded)
  );

  initial begin
    #1500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b0; load_req = 1'b0; dim = 9'd0; in_valid = 1'b0; in_data = 8'd0; proc_done = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, writeEnable, ready, err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl got in_ready/we/ready/err=%b want 0000", {in_ready, writeEnable, ready, err});
    end
    checks++;
    if (address !== 16'd0 || data_to_write !== 8'd0 || frames_loaded !== 8'd0) begin
      errors++;
      $display("FAIL reset_data got addr=%0d data=%0d frames=%0d want 0 0 0", address, data_to_write, frames_loaded);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || err !== 1'b0 || writeEnable !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle got in_ready=%b err=%b we=%b want 0 0 0", in_ready, err, writeEnable);
    end
    exp_frames = 0; last_addr = 0; last_data = 0;
  endtask

  // mode 0: in_valid with pct% probability; mode 1: valid on alternate cycles;
  // mode 2: always valid with data 10,20,30,...  abort_at >= 0 returns after that many beats.
  task automatic run_frame(input int d, input int mode, input int pct, input int abort_at);
    int total;
    int k;
    int cyc;
    int budget;
    bit pend;
    bit done;
    bit v;
    logic [7:0] dv;
    total = d * d; k = 0; cyc = 0; pend = 1'b0; done = 1'b0;
    budget = total * 20 + 40;
    load_req = 1'b1; dim = 9'(d);
    @(negedge clk);
    load_req = 1'b0;
    while (!done) begin
      checks++;
      if (in_ready !== (k < total)) begin
        errors++;
        $display("FAIL in_ready dim=%0d beat=%0d got %b want %b", d, k, in_ready, (k < total));
      end
      checks++;
      if (writeEnable !== pend) begin
        errors++;
        $display("FAIL write_strobe dim=%0d beat=%0d got %b want %b", d, k, writeEnable, pend);
      end
      checks++;
      if (address !== last_addr[15:0] || data_to_write !== last_data[7:0]) begin
        errors++;
        $display("FAIL write_bus dim=%0d got addr=%0d data=%0d want addr=%0d data=%0d",
                 d, address, data_to_write, last_addr, last_data);
      end
      checks++;
      if (ready !== (k == total && !pend)) begin
        errors++;
        $display("FAIL ready_timing dim=%0d beat=%0d got %b want %b", d, k, ready, (k == total && !pend));
      end
      checks++;
      if (err !== 1'b0 || frames_loaded !== exp_frames[7:0]) begin
        errors++;
        $display("FAIL load_status got err=%b frames=%0d want 0 %0d", err, frames_loaded, exp_frames);
      end
      if (k == total && !pend) begin
        done = 1'b1;
      end else if (abort_at >= 0 && k == abort_at) begin
        done = 1'b1;
      end else begin
        if (mode == 1) v = (cyc % 2 == 0);
        else if (mode == 2) v = 1'b1;
        else v = ($urandom_range(99) < pct);
        dv = (mode == 2) ? 8'(10 * (k + 1)) : 8'($urandom);
        in_valid = v; in_data = dv;
        pend = v && (k < total);
        if (pend) begin
          last_addr = k; last_data = int'(dv); k++;
        end
        cyc++;
        if (cyc > budget) begin
          errors++;
          $display("FAIL frame_timeout dim=%0d beats=%0d want %0d", d, k, total);
          done = 1'b1;
        end
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    $display("frame dim=%0d mode=%0d beats=%0d last_addr=%0d", d, mode, k, last_addr);
  endtask

  task automatic test_proc_done(input int hold);
    repeat (hold) begin
      load_req = 1'($urandom_range(1)); dim = 9'd2; in_valid = 1'($urandom_range(1));
      @(negedge clk);
      checks++;
      if (ready !== 1'b1 || in_ready !== 1'b0 || err !== 1'b0 || writeEnable !== 1'b0) begin
        errors++;
        $display("FAIL wait_hold got ready=%b in_ready=%b err=%b we=%b want 1 0 0 0", ready, in_ready, err, writeEnable);
      end
    end
    proc_done = 1'b1; load_req = 1'b1; dim = 9'd2; in_valid = 1'b0;
    @(negedge clk);
    proc_done = 1'b0; load_req = 1'b0;
    exp_frames = (exp_frames + 1) % 256;
    checks++;
    if (ready !== 1'b0 || frames_loaded !== exp_frames[7:0]) begin
      errors++;
      $display("FAIL proc_done got ready=%b frames=%0d want 0 %0d", ready, frames_loaded, exp_frames);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || writeEnable !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL no_new_load got in_ready=%b we=%b ready=%b want 0 0 0", in_ready, writeEnable, ready);
    end
    $display("proc_done frames=%0d", frames_loaded);
  endtask

  task automatic test_err();
    int bad [4] = '{0, 257, 300, 511};
    foreach (bad[i]) begin
      load_req = 1'b1; dim = 9'(bad[i]);
      @(negedge clk);
      load_req = 1'b0;
      checks++;
      if (err !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL err_pulse dim=%0d got err=%b in_ready=%b want 1 0", bad[i], err, in_ready);
      end
      @(negedge clk);
      checks++;
      if (err !== 1'b0 || in_ready !== 1'b0 || writeEnable !== 1'b0) begin
        errors++;
        $display("FAIL err_width dim=%0d got err=%b in_ready=%b we=%b want 0 0 0", bad[i], err, in_ready, writeEnable);
      end
      $display("reject dim=%0d", bad[i]);
    end
  endtask

  task automatic test_idle_proc_done();
    proc_done = 1'b1;
    @(negedge clk);
    proc_done = 1'b0;
    checks++;
    if (frames_loaded !== exp_frames[7:0] || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_proc_done got frames=%0d in_ready=%b want %0d 0", frames_loaded, in_ready, exp_frames);
    end
    $display("idle proc_done ignored frames=%0d", frames_loaded);
  endtask

  task automatic test_reset_abort();
    run_frame(4, 0, 100, 5);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++;
    if ({in_ready, writeEnable, ready, err} !== 4'b0000 || address !== 16'd0 ||
        data_to_write !== 8'd0 || frames_loaded !== 8'd0) begin
      errors++;
      $display("FAIL abort_reset got ctrl=%b addr=%0d data=%0d frames=%0d want 0000 0 0 0",
               {in_ready, writeEnable, ready, err}, address, data_to_write, frames_loaded);
    end
    exp_frames = 0; last_addr = 0; last_data = 0;
    @(negedge clk);
    run_frame(1, 0, 60, -1);
    test_proc_done(2);
  endtask

  task automatic test_random_frames();
    repeat (5) begin
      run_frame($urandom_range(1, 16), 0, $urandom_range(30, 100), -1);
      test_proc_done($urandom_range(0, 4));
    end
  endtask

  initial begin
    test_reset();
    run_frame(2, 2, 100, -1);
    test_proc_done(3);
    run_frame(3, 1, 100, -1);
    test_proc_done(1);
    test_err();
    test_idle_proc_done();
    test_random_frames();
    test_reset_abort();
    run_frame(256, 0, 100, -1);
    test_proc_done(1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
